// File: rtl/seg7_page_sched.sv
`default_nettype none
// seg7_page_sched: round-robin pager that time-shares one 32-bit seven-segment display
// among NUM_SRC sources, with dwell timer, owner lock, manual advance and blank gap.
module seg7_page_sched #(
   parameter int NUM_SRC      = 4,
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int GAP_CYCLES   = 2,
   parameter int CNT_W        = 27,
   parameter int IDX_W        = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SRC-1:0]     i_req,
   input  logic [32*NUM_SRC-1:0]  i_data,
   input  logic [NUM_SRC-1:0]     i_lock,
   input  logic                   i_next,
   output logic [NUM_SRC-1:0]     o_grant,
   output logic [IDX_W-1:0]       o_page,
   output logic [31:0]            o_disp_data,
   output logic                   o_valid,
   output logic                   o_switch
);

   localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_MAX   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SRC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [IDX_W-1:0]     ptr, ptr_nx;
   logic [NUM_SRC-1:0]   grant_nx;
   logic [IDX_W-1:0]     page_nx;
   logic [31:0]          data_nx;
   logic                 valid_nx;
   logic                 switch_nx;

   logic [31:0]          words [NUM_SRC];
   logic [IDX_W-1:0]     win;
   logic [IDX_W-1:0]     idx;
   logic                 win_found;
   logic                 owner_req;
   logic                 owner_lock;
   logic                 others_req;
   logic                 expire;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_words
      assign words[k] = i_data[32*k +: 32];
   end

   // Rotating priority search starting at the round-robin pointer.
   always_comb begin
      win       = '0;
      win_found = 1'b0;
      idx       = ptr;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!win_found && i_req[idx]) begin
            win_found = 1'b1;
            win       = idx;
         end
         idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
   end

   assign owner_req  = i_req[o_page];
   assign owner_lock = i_lock[o_page];
   assign others_req = |(i_req & ~o_grant);
   assign expire     = ((cnt == DWELL_MAX) || i_next) && !owner_lock;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      ptr_nx    = ptr;
      grant_nx  = o_grant;
      page_nx   = o_page;
      data_nx   = o_disp_data;
      valid_nx  = o_valid;
      switch_nx = 1'b0;

      case (state)
         IDLE: begin
            data_nx = '0;
            if (win_found) begin
               state_nx  = SHOW;
               cnt_nx    = '0;
               grant_nx  = NUM_SRC'(1) << win;
               page_nx   = win;
               ptr_nx    = (win == LAST_IDX) ? '0 : win + IDX_W'(1);
               valid_nx  = 1'b1;
               switch_nx = 1'b1;
            end
         end
         SHOW: begin
            data_nx = words[o_page];
            if (!owner_req || expire) begin
               if (others_req) begin
                  state_nx = GAP;
                  cnt_nx   = '0;
                  grant_nx = '0;
                  valid_nx = 1'b0;
               end else if (owner_req) begin
                  cnt_nx = '0;
               end else begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
                  grant_nx = '0;
                  valid_nx = 1'b0;
                  data_nx  = '0;
               end
            end else if (cnt != DWELL_MAX) begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt != GAP_MAX) begin
               cnt_nx = cnt + CNT_W'(1);
            end else if (win_found) begin
               state_nx  = SHOW;
               cnt_nx    = '0;
               grant_nx  = NUM_SRC'(1) << win;
               page_nx   = win;
               ptr_nx    = (win == LAST_IDX) ? '0 : win + IDX_W'(1);
               valid_nx  = 1'b1;
               switch_nx = 1'b1;
            end else begin
               state_nx = IDLE;
               cnt_nx   = '0;
               data_nx  = '0;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            grant_nx = '0;
            valid_nx = 1'b0;
            data_nx  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         ptr         <= '0;
         o_grant     <= '0;
         o_page      <= '0;
         o_disp_data <= '0;
         o_valid     <= 1'b0;
         o_switch    <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         ptr         <= ptr_nx;
         o_grant     <= grant_nx;
         o_page      <= page_nx;
         o_disp_data <= data_nx;
         o_valid     <= valid_nx;
         o_switch    <= switch_nx;
      end
   end

endmodule
`default_nettype wire
